adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; slice width 8, slice count 4, operand width 32 are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block accepts request; high exactly when state is IDLE (combinational from state).
REQ-006 a  input  32  operand A, sampled on accept.
REQ-007 b  input  32  operand B, sampled on accept.
REQ-008 cin  input  1  carry into slice 0, sampled on accept.
REQ-009 chain  input  1  1 = carries ripple between slices (full 32-bit add); 0 = four independent 8-bit lane adds; sampled on accept.
REQ-010 out_valid  output  1  result valid (registered).
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  32  result (registered).
REQ-013 cout  output  1  carry out of slice 3 when chain=1; 0 when chain=0.
REQ-014 lane_cout  output  4  raw 8-bit carry out of each slice, bit i = slice i, both modes.
REQ-015 busy  output  1  high in CALC or DONE.

Function
REQ-016 States SHALL be IDLE, CALC, DONE; one 8-bit adder instance SHALL be time-shared across the four slices.
REQ-017 Accept = in_valid && in_ready at a rising edge: latch a, b, cin, chain; clear sum, lane_cout, cout; slice index idx=0; go CALC.
REQ-018 In CALC, each edge SHALL compute slice idx: {c, s} = a[8*idx+7:8*idx] + b[8*idx+7:8*idx] + cin_slice; write s to sum[8*idx+7:8*idx], c to lane_cout[idx]; idx increments.
REQ-019 cin_slice: idx=0 -> latched cin when chain=1, 0 when chain=0; idx>0 -> carry of slice idx-1 when chain=1, 0 when chain=0.
REQ-020 On the CALC edge with idx=3: go DONE, out_valid=1, cout set per REQ-013.
REQ-021 Latency: accept at edge E0 -> out_valid high after edge E4 (4 cycles).
REQ-022 In DONE, out_valid, sum, cout, lane_cout SHALL hold stable until out_valid && out_ready; on that edge out_valid=0, state IDLE.
REQ-023 sum, cout, lane_cout SHALL retain the last result in IDLE until the next accept.
REQ-024 in_valid, a, b, cin, chain SHALL be ignored outside IDLE; no request overlap, no queuing.
REQ-025 Maximum throughput: one operation per 6 cycles (accept, 4 CALC, handshake edge; IDLE next cycle allows accept).
REQ-026 All arithmetic unsigned modulo 2^8 per slice; carries beyond slice 3 appear only on cout/lane_cout[3].

Reset
REQ-027 rst high at an edge SHALL force state IDLE, idx=0, out_valid=0, sum=0, cout=0, lane_cout=0, busy=0, in_ready=1 after that edge, in any state.
REQ-028 Reset mid-operation SHALL discard the in-flight operation with no out_valid pulse.
REQ-029 rst SHALL dominate in_valid and out_ready on the same edge.

Verification
REQ-030 chain=1, a=0x000000FF, b=0x00000001, cin=0 -> 4 cycles after accept out_valid=1, sum=0x00000100, cout=0, lane_cout=4'b0001.
REQ-031 chain=0, same operands -> sum=0x00000000, cout=0, lane_cout=4'b0001; cin=1 with chain=0 has no effect.
REQ-032 chain=1, a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, lane_cout=4'b1111.
REQ-033 Result pending, out_ready low 3 cycles, in_valid high with new operands -> out_valid, sum stable, in_ready=0, new operands ignored; out_ready high -> handshake, IDLE next cycle, in_ready=1.
REQ-034 rst asserted during second CALC cycle -> after edge: out_valid=0, sum=0, busy=0, in_ready=1; no result ever produced for that request.
REQ-035 in_valid and out_ready held high, chain=1, a=0x12345678, b=0x11111111 repeated -> accepts every 6 cycles, each result sum=0x23456789, cout=0.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Sequential 32-bit adder built from one 8-bit adder reused over four slices.
// chain=1 ripples carries between slices (full 32-bit add); chain=0 gives four
// independent 8-bit lane adds. Request/result use valid/ready handshakes.
module adder_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        chain,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic [3:0]  lane_cout,
  output logic        busy
);

  localparam int DATA_W = 8;
  localparam int STAGES = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_cin;
  logic              r_chain;
  logic              r_carry;
  logic [1:0]        r_idx;
  logic [31:0]       r_sum;
  logic              r_cout;
  logic [3:0]        r_lane_cout;
  logic              r_out_valid;

  logic [DATA_W-1:0] w_a_slice;
  logic [DATA_W-1:0] w_b_slice;
  logic              w_cin_slice;
  logic [DATA_W:0]   w_add;
  logic              w_accept;
  logic              w_release;
  logic              w_last;

  // Unsigned 8-bit add with carry in; the MSB of the result is the carry out.
  function automatic logic [DATA_W:0] add8(input logic [DATA_W-1:0] x,
                                           input logic [DATA_W-1:0] y,
                                           input logic              ci);
    return {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, ci};
  endfunction

  // Handshake and slice-sequencing decodes.
  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_release = (r_state == DONE) && out_ready;
  assign w_last    = (r_state == CALC) && (r_idx == 2'(STAGES - 1));

  // The single shared adder: slice operands picked by idx; carry in is gated
  // to zero in lane mode so the four lanes stay independent.
  assign w_a_slice   = r_a[{r_idx, 3'b000} +: DATA_W];
  assign w_b_slice   = r_b[{r_idx, 3'b000} +: DATA_W];
  assign w_cin_slice = r_chain & ((r_idx == 2'd0) ? r_cin : r_carry);
  assign w_add       = add8(w_a_slice, w_b_slice, w_cin_slice);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> CALC on accept, CALC for four slices, DONE until
  // the consumer takes the result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = CALC;
      CALC:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept; held unchanged for the whole operation.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_cin   <= cin;
      r_chain <= chain;
    end
  end

  // Result accumulation: one slice of sum and lane carry written per CALC edge;
  // results clear on accept and otherwise hold the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= 2'd0;
      r_carry     <= 1'b0;
      r_sum       <= 32'd0;
      r_cout      <= 1'b0;
      r_lane_cout <= 4'd0;
    end else if (w_accept) begin
      r_idx       <= 2'd0;
      r_carry     <= 1'b0;
      r_sum       <= 32'd0;
      r_cout      <= 1'b0;
      r_lane_cout <= 4'd0;
    end else if (r_state == CALC) begin
      r_sum[{r_idx, 3'b000} +: DATA_W] <= w_add[DATA_W-1:0];
      r_lane_cout[r_idx]               <= w_add[DATA_W];
      r_carry                          <= w_add[DATA_W];
      r_idx                            <= r_idx + 2'd1;
      if (w_last) begin
        r_cout <= r_chain & w_add[DATA_W];
      end
    end
  end

  // Result-valid flag: raised with the final slice, dropped on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else if (w_last) begin
      r_out_valid <= 1'b1;
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign lane_cout = r_lane_cout;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl: a transaction-level reference model runs
// alongside the DUT and every cycle is compared against it, with literal
// expectations on the hand-computed vectors.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        chain;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic [3:0]  lane_cout;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .chain     (chain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .lane_cout (lane_cout),
    .busy      (busy)
  );

  // Reference result packed as {lane_cout, cout, sum}.
  function automatic logic [36:0] model_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic ch);
    logic [32:0] full;
    logic [32:0] part;
    logic [32:0] mask;
    logic [8:0]  l;
    logic [31:0] s;
    logic        co;
    logic [3:0]  lc;
    s  = 32'd0;
    co = 1'b0;
    lc = 4'd0;
    if (ch) begin
      full = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      s    = full[31:0];
      co   = full[32];
      for (int i = 0; i < 4; i++) begin
        mask  = (33'd1 << (8 * (i + 1))) - 33'd1;
        part  = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {32'd0, ci};
        lc[i] = part[8 * (i + 1)];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        l             = {1'b0, x[8*i +: 8]} + {1'b0, y[8*i +: 8]};
        s[8*i +: 8]   = l[7:0];
        lc[i]         = l[8];
      end
    end
    return {lc, co, s};
  endfunction

  // Transaction model: accept when idle, result 4 edges later, held until taken.
  logic        m_busy;
  logic        m_ov;
  int          m_cnt;
  logic [36:0] m_res;
  logic [36:0] p_res;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_ov   <= 1'b0;
      m_cnt  <= 0;
      m_res  <= 37'd0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        p_res  <= model_res(a, b, cin, chain);
      end
    end else if (!m_ov) begin
      if (m_cnt == 3) begin
        m_ov  <= 1'b1;
        m_res <= p_res;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (out_ready) begin
      m_ov   <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("m_in_ready", 32'(in_ready), 32'(!m_busy));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_out_valid", 32'(out_valid), 32'(m_ov));
    if (!m_busy || m_ov) begin
      chk("m_sum", sum, m_res[31:0]);
      chk("m_cout", 32'(cout), 32'(m_res[32]));
      chk("m_lane_cout", 32'(lane_cout), 32'(m_res[36:33]));
    end
  endtask

  // Advance one clock and compare on the falling edge.
  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!out_valid && n < 12) begin
      step();
      n++;
    end
  endtask

  task automatic do_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tci, input logic tch,
                       input logic [31:0] es, input logic ec, input logic [3:0] el);
    int n;
    a = ta; b = tb; cin = tci; chain = tch; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    a = 32'hDEADBEEF; b = 32'hCAFEF00D; cin = ~tci; chain = ~tch;
    wait_ov(n);
    chk({name, "_latency"}, 32'(n), 32'd4);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_lane_cout"}, 32'(lane_cout), 32'(el));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_hs_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_hs_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; cin = 1'b0; chain = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_lane_cout", 32'(lane_cout), 32'd0);

    do_op("chain_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b1, 32'h00000100, 1'b0, 4'b0001);
    do_op("lane_ff_1",    32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0001);
    do_op("lane_ff_1_ci", 32'h000000FF, 32'h00000001, 1'b1, 1'b0, 32'h00000000, 1'b0, 4'b0001);
    do_op("chain_all1",   32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 4'b1111);
    do_op("lane_80",      32'h80808080, 32'h80808080, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1111);
    do_op("chain_mixed",  32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h23456789, 1'b0, 4'b0000);
    do_op("chain_top",    32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h00000001, 1'b1, 4'b1000);

    // Result held under back-pressure while a new request is offered.
    a = 32'h000000FF; b = 32'h00000001; cin = 1'b0; chain = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_ov(n);
    chk("bp_latency", 32'(n), 32'd4);
    a = 32'h11111111; b = 32'h22222222; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", sum, 32'h00000100);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
    chk("bp_hs_out_valid", 32'(out_valid), 32'd0);
    step();
    chk("bp_idle_retain", sum, 32'h00000100);

    // Reset during the second CALC cycle discards the operation.
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; chain = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_lane_cout", 32'(lane_cout), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mid_rst_no_result", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Back-to-back operation at full throughput.
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; chain = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_valid && in_ready) acc++;
      step();
      if (out_valid) begin
        chk("tp_sum", sum, 32'h23456789);
        chk("tp_cout", 32'(cout), 32'd0);
      end
    end
    chk("tp_accepts", 32'(acc), 32'd5);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("tp_drained", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
